nv_nvdla_nocif_write_rsp: RTL and testbench
===========================================

NV_NVDLA_NOCIF_WRITE_RSP -- requirements
Module: nv_nvdla_nocif_write_rsp

Interface
REQ-001 SHALL have parameter AW_DEPTH, default 8, meaning AW context FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter B_DEPTH, default 8, meaning pending B-response FIFO entries (power of two, 2..16).
REQ-003 SHALL have port nvdla_core_clk  in  1  the single clock.
REQ-004 SHALL have port nvdla_core_rstn  in  1  reset; synchronous, active-low.
REQ-005 SHALL have port mcif2noc_axi_aw_awvalid  in  1  write address valid.
REQ-006 SHALL have port mcif2noc_axi_aw_awready  out  1  write address ready.
REQ-007 SHALL have port mcif2noc_axi_aw_awid  in  8  write ID.
REQ-008 SHALL have port mcif2noc_axi_aw_awlen  in  2  beats minus one (0..3).
REQ-009 SHALL have port mcif2noc_axi_w_wvalid  in  1  write data valid (data bits not consumed).
REQ-010 SHALL have port mcif2noc_axi_w_wready  out  1  write data ready.
REQ-011 SHALL have port mcif2noc_axi_w_wlast  in  1  last beat of burst.
REQ-012 SHALL have port noc2mcif_axi_b_bvalid  out  1  write response valid.
REQ-013 SHALL have port noc2mcif_axi_b_bready  in  1  write response ready.
REQ-014 SHALL have port noc2mcif_axi_b_bid  out  8  response ID, equals the awid of the completed burst.
REQ-015 SHALL have port nocif_wr_len_err  out  1  sticky burst-length mismatch flag.

Function
REQ-016 SHALL store {awid, awlen} in an in-order AW FIFO on awvalid & awready.
REQ-017 SHALL drive awready = AW FIFO not full, computed from registered occupancy; no bypass when full and popping in the same cycle.
REQ-018 SHALL drive wready = AW FIFO not empty & B FIFO not full; a W beat SHALL never be accepted without an AW at the FIFO head.
REQ-019 SHALL reject W in the same cycle its AW is written to an empty FIFO; earliest W acceptance is one cycle after AW acceptance.
REQ-020 SHALL count accepted beats of the head burst in a 2-bit counter, cleared on burst completion.
REQ-021 SHALL complete a burst on an accepted beat with wlast=1: pop the AW head, push its awid into the B FIFO, clear the beat counter, all in that cycle.
REQ-022 SHALL drive bvalid = B FIFO not empty and bid = B FIFO head; the entry pops on bvalid & bready.
REQ-023 SHALL hold bvalid and bid stable while bready is low.
REQ-024 SHALL assert bvalid no earlier than one cycle after the wlast beat is accepted (latency 1 with empty B FIFO).
REQ-025 SHALL issue B responses in AW acceptance order, regardless of ID, one per burst.
REQ-026 SHALL support simultaneous push and pop on each FIFO; occupancy is unchanged and no entry is lost or duplicated.
REQ-027 SHALL wrap FIFO read/write pointers modulo depth with an extra wrap bit to distinguish full from empty.
REQ-028 SHALL hold wready low while the B FIFO is full, including the cycle in which it pops.

Reset
REQ-029 SHALL, on nvdla_core_rstn low at a clock edge, empty both FIFOs, clear the beat counter and clear nocif_wr_len_err.
REQ-030 SHALL drive awready=0, wready=0, bvalid=0, bid=0, nocif_wr_len_err=0 during reset.
REQ-031 SHALL discard partially received bursts and un-returned responses when reset is asserted mid-operation.

Configuration
REQ-032 SHALL use macro NVDLA_NOCIF_WR_LEN_CHECK_EN to compile in burst-length checking.
REQ-033 SHALL, with the macro defined, set nocif_wr_len_err on an accepted beat where wlast=1 and count != awlen, or wlast=0 and count == awlen; the flag holds until reset; completion still follows wlast only.
REQ-034 SHALL, without the macro, tie nocif_wr_len_err to 0 and include no checking logic.

Verification
REQ-035 SHALL test single burst: AW id=0x04 len=1 at cycle 0, W beats at cycles 1-2 (wlast at 2), bready=1 -> bvalid=1, bid=0x04 at cycle 3 only.
REQ-036 SHALL test ordering: AW ids 0x01,0x03,0x00 with len 0, three wlast beats -> B ids 0x01,0x03,0x00 in order.
REQ-037 SHALL test backpressure: bready=0, 9 len-0 bursts (default depths) -> 8 B entries queued, wready=0 on the 9th beat; raise bready -> all 9 bids returned in order.
REQ-038 SHALL test AW full: 8 AWs and no W -> awready=0 at the 9th; one burst completes -> awready=1 the next cycle.
REQ-039 SHALL test length check: with the macro, AW len=2 and wlast on beat 2 -> nocif_wr_len_err=1 sticky and bid returned; without the macro -> error output stays 0.
REQ-040 SHALL test reset mid-burst: reset after 1 of 4 beats -> bvalid=0 and awready=0 in reset, awready=1 after release, a fresh burst completes normally.

Source files
------------

// File: rtl/nv_nvdla_nocif_write_rsp.sv
// Write-response tracker: queues AW contexts, counts W beats per burst and returns in-order B responses.
// Optional burst-length checking is compiled in with `define NVDLA_NOCIF_WR_LEN_CHECK_EN.
module nv_nvdla_nocif_write_rsp #(
    parameter int AW_DEPTH = 8,
    parameter int B_DEPTH  = 8
) (
    input  logic       nvdla_core_clk,
    input  logic       nvdla_core_rstn,
    input  logic       mcif2noc_axi_aw_awvalid,
    output logic       mcif2noc_axi_aw_awready,
    input  logic [7:0] mcif2noc_axi_aw_awid,
    input  logic [1:0] mcif2noc_axi_aw_awlen,
    input  logic       mcif2noc_axi_w_wvalid,
    output logic       mcif2noc_axi_w_wready,
    input  logic       mcif2noc_axi_w_wlast,
    output logic       noc2mcif_axi_b_bvalid,
    input  logic       noc2mcif_axi_b_bready,
    output logic [7:0] noc2mcif_axi_b_bid,
    output logic       nocif_wr_len_err
);

    localparam int AA = $clog2(AW_DEPTH);
    localparam int BA = $clog2(B_DEPTH);

    logic [9:0]  r_aw_mem [AW_DEPTH];
    logic [7:0]  r_b_mem  [B_DEPTH];

    logic [AA:0] r_aw_wp;
    logic [AA:0] r_aw_rp;
    logic [BA:0] r_b_wp;
    logic [BA:0] r_b_rp;
    logic        r_awready;
    logic        r_wready;
    logic        r_bvalid;
    logic [7:0]  r_bid;
    logic [1:0]  r_beat_cnt;

    logic        w_aw_push;
    logic        w_w_acc;
    logic        w_burst_done;
    logic        w_b_pop;
    logic [AA:0] w_aw_wp_nxt;
    logic [AA:0] w_aw_rp_nxt;
    logic [BA:0] w_b_wp_nxt;
    logic [BA:0] w_b_rp_nxt;
    logic        w_aw_full_nxt;
    logic        w_aw_empty_nxt;
    logic        w_b_full_nxt;
    logic        w_b_empty_nxt;
    logic [7:0]  w_head_id;
    logic [1:0]  w_head_len;
    logic [7:0]  w_b_head_nxt;

    // Handshakes and next-state FIFO pointers/flags
    always_comb begin
        w_aw_push    = mcif2noc_axi_aw_awvalid & r_awready;
        w_w_acc      = mcif2noc_axi_w_wvalid & r_wready;
        w_burst_done = w_w_acc & mcif2noc_axi_w_wlast;
        w_b_pop      = r_bvalid & noc2mcif_axi_b_bready;

        w_aw_wp_nxt  = r_aw_wp + {{AA{1'b0}}, w_aw_push};
        w_aw_rp_nxt  = r_aw_rp + {{AA{1'b0}}, w_burst_done};
        w_b_wp_nxt   = r_b_wp + {{BA{1'b0}}, w_burst_done};
        w_b_rp_nxt   = r_b_rp + {{BA{1'b0}}, w_b_pop};

        w_aw_full_nxt  = (w_aw_wp_nxt[AA] != w_aw_rp_nxt[AA]) &&
                         (w_aw_wp_nxt[AA-1:0] == w_aw_rp_nxt[AA-1:0]);
        w_aw_empty_nxt = (w_aw_wp_nxt == w_aw_rp_nxt);
        w_b_full_nxt   = (w_b_wp_nxt[BA] != w_b_rp_nxt[BA]) &&
                         (w_b_wp_nxt[BA-1:0] == w_b_rp_nxt[BA-1:0]);
        w_b_empty_nxt  = (w_b_wp_nxt == w_b_rp_nxt);

        w_head_id  = r_aw_mem[r_aw_rp[AA-1:0]][9:2];
        w_head_len = r_aw_mem[r_aw_rp[AA-1:0]][1:0];

        // An id pushed this cycle into a draining B FIFO is the next head before it lands in memory
        if (w_burst_done && (w_b_rp_nxt[BA-1:0] == r_b_wp[BA-1:0])) begin
            w_b_head_nxt = w_head_id;
        end else begin
            w_b_head_nxt = r_b_mem[w_b_rp_nxt[BA-1:0]];
        end
    end

    // AW context storage
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rstn && w_aw_push) begin
            r_aw_mem[r_aw_wp[AA-1:0]] <= {mcif2noc_axi_aw_awid, mcif2noc_axi_aw_awlen};
        end
    end

    // Pending B-response id storage
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rstn && w_burst_done) begin
            r_b_mem[r_b_wp[BA-1:0]] <= w_head_id;
        end
    end

    // Pointers, beat counter and registered handshake outputs
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            r_aw_wp    <= {(AA+1){1'b0}};
            r_aw_rp    <= {(AA+1){1'b0}};
            r_b_wp     <= {(BA+1){1'b0}};
            r_b_rp     <= {(BA+1){1'b0}};
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bid      <= 8'h00;
            r_beat_cnt <= 2'd0;
        end else begin
            r_aw_wp   <= w_aw_wp_nxt;
            r_aw_rp   <= w_aw_rp_nxt;
            r_b_wp    <= w_b_wp_nxt;
            r_b_rp    <= w_b_rp_nxt;
            r_awready <= ~w_aw_full_nxt;
            r_wready  <= ~w_aw_empty_nxt & ~w_b_full_nxt;
            r_bvalid  <= ~w_b_empty_nxt;
            r_bid     <= w_b_empty_nxt ? 8'h00 : w_b_head_nxt;
            if (w_burst_done) begin
                r_beat_cnt <= 2'd0;
            end else if (w_w_acc) begin
                r_beat_cnt <= r_beat_cnt + 2'd1;
            end else begin
                r_beat_cnt <= r_beat_cnt;
            end
        end
    end

    assign mcif2noc_axi_aw_awready = r_awready;
    assign mcif2noc_axi_w_wready   = r_wready;
    assign noc2mcif_axi_b_bvalid   = r_bvalid;
    assign noc2mcif_axi_b_bid      = r_bid;

`ifdef NVDLA_NOCIF_WR_LEN_CHECK_EN
    logic r_len_err;
    logic w_len_err_hit;

    // A beat is wrong if wlast disagrees with whether the count has reached awlen
    always_comb begin
        w_len_err_hit = w_w_acc &&
                        ((mcif2noc_axi_w_wlast && (r_beat_cnt != w_head_len)) ||
                         (!mcif2noc_axi_w_wlast && (r_beat_cnt == w_head_len)));
    end

    // Sticky length-error flag, cleared only by reset
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            r_len_err <= 1'b0;
        end else if (w_len_err_hit) begin
            r_len_err <= 1'b1;
        end else begin
            r_len_err <= r_len_err;
        end
    end

    assign nocif_wr_len_err = r_len_err;
`else
    logic w_unused_len;
    assign w_unused_len     = ^{w_head_len, r_beat_cnt};
    assign nocif_wr_len_err = 1'b0;
`endif

endmodule

// File: tb/tb_nv_nvdla_nocif_write_rsp.sv
// Self-checking bench for nv_nvdla_nocif_write_rsp: directed scenarios plus random traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_nv_nvdla_nocif_write_rsp;

    localparam int AWD = 8;
    localparam int BD  = 8;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       awvalid = 1'b0;
    logic       awready;
    logic [7:0] awid = 8'h00;
    logic [1:0] awlen = 2'd0;
    logic       wvalid = 1'b0;
    logic       wready;
    logic       wlast = 1'b0;
    logic       bvalid;
    logic       bready = 1'b0;
    logic [7:0] bid;
    logic       len_err;

    nv_nvdla_nocif_write_rsp #(.AW_DEPTH(AWD), .B_DEPTH(BD)) dut (
        .nvdla_core_clk          (clk),
        .nvdla_core_rstn         (rstn),
        .mcif2noc_axi_aw_awvalid (awvalid),
        .mcif2noc_axi_aw_awready (awready),
        .mcif2noc_axi_aw_awid    (awid),
        .mcif2noc_axi_aw_awlen   (awlen),
        .mcif2noc_axi_w_wvalid   (wvalid),
        .mcif2noc_axi_w_wready   (wready),
        .mcif2noc_axi_w_wlast    (wlast),
        .noc2mcif_axi_b_bvalid   (bvalid),
        .noc2mcif_axi_b_bready   (bready),
        .noc2mcif_axi_b_bid      (bid),
        .nocif_wr_len_err        (len_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] id;
        logic [1:0] len;
    } aw_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    aw_t        aw_q[$];
    logic [7:0] b_q[$];
    logic [7:0] got[$];
    int         cnt = 0;
    bit         m_err = 1'b0;

`ifdef NVDLA_NOCIF_WR_LEN_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, drive inputs, advance the model
    task automatic step(input bit awv, input logic [7:0] id, input logic [1:0] len,
                        input bit wv, input bit wl, input bit br);
        bit         e_awr;
        bit         e_wr;
        bit         e_bv;
        logic [7:0] e_bid;
        aw_t        h;
        e_awr = (aw_q.size() < AWD);
        e_wr  = (aw_q.size() > 0) && (b_q.size() < BD);
        e_bv  = (b_q.size() > 0);
        e_bid = e_bv ? b_q[0] : 8'h00;
        chk("awready", {31'd0, awready}, {31'd0, e_awr});
        chk("wready",  {31'd0, wready},  {31'd0, e_wr});
        chk("bvalid",  {31'd0, bvalid},  {31'd0, e_bv});
        chk("bid",     {24'd0, bid},     {24'd0, e_bid});
        chk("len_err", {31'd0, len_err}, {31'd0, m_err});
        awvalid = awv; awid = id; awlen = len;
        wvalid = wv; wlast = wl; bready = br;
        if (e_bv && br) begin
            got.push_back(bid);
            void'(b_q.pop_front());
        end
        if (wv && e_wr) begin
            h = aw_q[0];
            if (ERR_EN && ((wl && cnt != int'(h.len)) || (!wl && cnt == int'(h.len)))) m_err = 1'b1;
            if (wl) begin
                cnt = 0;
                void'(aw_q.pop_front());
                b_q.push_back(h.id);
            end else begin
                cnt = (cnt + 1) % 4;
            end
        end
        if (awv && e_awr) aw_q.push_back({id, len});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_awready", {31'd0, awready}, 32'd0);
        chk("rst_wready",  {31'd0, wready},  32'd0);
        chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
        chk("rst_bid",     {24'd0, bid},     32'd0);
        chk("rst_len_err", {31'd0, len_err}, 32'd0);
        aw_q.delete(); b_q.delete(); got.delete();
        cnt = 0; m_err = 1'b0;
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (aw_q.size() > 0 || b_q.size() > 0); k++) begin
            step(1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 1'b1);
        end
        chk("drain_timeout", aw_q.size() + b_q.size(), 32'd0);
    endtask

    initial begin
        logic [7:0] exp036[3];
        bit         wl_r;
        exp036[0] = 8'h01; exp036[1] = 8'h03; exp036[2] = 8'h00;

        @(posedge clk);
        #1;
        do_reset();

        // Single burst, len=1
        step(1'b1, 8'h04, 2'd1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 1'b1);
        chk("t035_bvalid_early", {31'd0, bvalid}, 32'd0);
        step(1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 1'b1);
        chk("t035_bvalid", {31'd0, bvalid}, 32'd1);
        chk("t035_bid", {24'd0, bid}, 32'h04);
        step(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("t035_bvalid_once", {31'd0, bvalid}, 32'd0);

        // In-order responses independent of ID
        got.delete();
        step(1'b1, 8'h01, 2'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h03, 2'd0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 8'h00, 2'd0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("t036_count", got.size(), 32'd3);
        for (int i = 0; i < got.size() && i < 3; i++) chk("t036_order", {24'd0, got[i]}, {24'd0, exp036[i]});

        // AW FIFO full, then B FIFO full backpressure
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 8'h10 + 8'(i), 2'd0, 1'b0, 1'b0, 1'b0);
        chk("t038_awready_full", {31'd0, awready}, 32'd0);
        step(1'b1, 8'h18, 2'd0, 1'b1, 1'b1, 1'b0);
        chk("t038_awready_back", {31'd0, awready}, 32'd1);
        step(1'b1, 8'h18, 2'd0, 1'b0, 1'b0, 1'b0);
        repeat (7) step(1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 1'b0);
        chk("t037_wready_bfull", {31'd0, wready}, 32'd0);
        step(1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 1'b0);
        chk("t037_wready_bfull2", {31'd0, wready}, 32'd0);
        got.delete();
        drain();
        chk("t037_count", got.size(), 32'd9);
        for (int i = 0; i < got.size() && i < 9; i++) chk("t037_order", {24'd0, got[i]}, 32'h10 + i);

        // Burst-length check: len=2 but wlast on the second beat
        do_reset();
        step(1'b1, 8'h20, 2'd2, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 1'b1);
        chk("t039_err", {31'd0, len_err}, {31'd0, ERR_EN});
        chk("t039_bvalid", {31'd0, bvalid}, 32'd1);
        chk("t039_bid", {24'd0, bid}, 32'h20);
        step(1'b1, 8'h21, 2'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("t039_err_sticky", {31'd0, len_err}, {31'd0, ERR_EN});

        // Reset in the middle of a 4-beat burst
        step(1'b1, 8'h30, 2'd3, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 1'b1);
        do_reset();
        chk("t040_awready", {31'd0, awready}, 32'd1);
        step(1'b1, 8'h31, 2'd1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 1'b1);
        chk("t040_bvalid", {31'd0, bvalid}, 32'd1);
        chk("t040_bid", {24'd0, bid}, 32'h31);
        step(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1);

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (aw_q.size() > 0 && $urandom_range(0, 9) != 0) wl_r = (cnt == int'(aw_q[0].len));
            else wl_r = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom),
                 1'($urandom_range(0, 1)), wl_r, ($urandom_range(0, 9) < 7));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
